// File: rtl/vga_mem_intf.sv
// Frame-buffer reader: prefetches packed BRAM words one word ahead of the beam
// and unpacks them into one pixel per pixel-clock cycle.
module vga_mem_intf #(
   parameter int PXL_WIDTH         = 1,
   parameter int PXL_PER_ROW       = 8,
   parameter int WIDTH_PX          = 640,
   parameter int HEIGHT_PX         = 480,
   parameter int H_B_PORCH_MAX_PX  = 144,
   parameter int V_B_PORCH_MAX_LNS = 35,
   parameter int PREFETCH_PX       = 4,
   parameter int PXL_CTR_WIDTH     = 10,
   parameter int LN_CTR_WIDTH      = 10,
   parameter int MEM_DEPTH         = 38400,
   parameter int ADDR_WIDTH        = 16
) (
   input  logic                             clk_i,
   input  logic                             rstn_i,
   input  logic [PXL_CTR_WIDTH-1:0]         pxl_ctr_i,
   input  logic [LN_CTR_WIDTH-1:0]          line_ctr_i,
   output logic                             mem_en_o,
   output logic [ADDR_WIDTH-1:0]            mem_addr_o,
   input  logic [PXL_PER_ROW*PXL_WIDTH-1:0] mem_data_i,
   output logic [PXL_WIDTH-1:0]             mem_pxl_o,
   output logic                             underrun_o
);

   localparam int WORD_W = PXL_PER_ROW * PXL_WIDTH;
   localparam int WPL    = WIDTH_PX / PXL_PER_ROW;

   localparam logic [PXL_CTR_WIDTH-1:0] H_FIRST    = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX);
   localparam logic [PXL_CTR_WIDTH-1:0] PF_PX      = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX - PREFETCH_PX);
   localparam logic [PXL_CTR_WIDTH-1:0] PF_LAST    = PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX - 1);
   localparam logic [PXL_CTR_WIDTH-1:0] OFF_LAST   = PXL_CTR_WIDTH'(WIDTH_PX - 1);
   localparam logic [PXL_CTR_WIDTH-1:0] ISSUE_LAST = PXL_CTR_WIDTH'((WPL - 2) * PXL_PER_ROW);
   localparam logic [PXL_CTR_WIDTH-1:0] PPR        = PXL_CTR_WIDTH'(PXL_PER_ROW);
   localparam logic [PXL_CTR_WIDTH-1:0] SLOT_LAST  = PXL_CTR_WIDTH'(PXL_PER_ROW - 1);
   localparam logic [LN_CTR_WIDTH-1:0]  V_FIRST    = LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS);
   localparam logic [LN_CTR_WIDTH-1:0]  V_END      = LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS + HEIGHT_PX);
   localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREFETCH = 2'd1,
      S_ACTIVE   = 2'd2
   } state_t;

   state_t                   state_r;
   state_t                   state_s;
   logic [WORD_W-1:0]        sr_r;
   logic [WORD_W-1:0]        nw_r;
   logic                     nw_vld_r;
   logic                     issue_d_r;
   logic [ADDR_WIDTH-1:0]    addr_r;
   logic                     underrun_r;
   logic [PXL_CTR_WIDTH-1:0] off_s;
   logic [PXL_CTR_WIDTH-1:0] slot_s;
   logic                     vis_line_s;
   logic                     frame_sync_s;
   logic                     issue_s;
   logic                     load_s;
   logic                     flush_s;

   assign off_s        = pxl_ctr_i - H_FIRST;
   assign slot_s       = off_s % PPR;
   assign vis_line_s   = (line_ctr_i >= V_FIRST) && (line_ctr_i < V_END);
   assign frame_sync_s = (line_ctr_i == {LN_CTR_WIDTH{1'b0}}) && (pxl_ctr_i == {PXL_CTR_WIDTH{1'b0}});

   // Next-state, read-issue and word-load decode
   always_comb begin
      state_s = state_r;
      issue_s = 1'b0;
      load_s  = 1'b0;
      flush_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (vis_line_s && (pxl_ctr_i == PF_PX)) begin
               issue_s = 1'b1;
               state_s = S_PREFETCH;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_PREFETCH: begin
            if (pxl_ctr_i == PF_LAST) begin
               load_s  = 1'b1;
               state_s = S_ACTIVE;
            end else begin
               state_s = S_PREFETCH;
            end
         end
         S_ACTIVE: begin
            if ((slot_s == {PXL_CTR_WIDTH{1'b0}}) && (off_s <= ISSUE_LAST)) begin
               issue_s = 1'b1;
            end else begin
               issue_s = 1'b0;
            end
            if (off_s == OFF_LAST) begin
               flush_s = 1'b1;
               state_s = S_IDLE;
            end else if (slot_s == SLOT_LAST) begin
               load_s = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      // Frame sync also abandons any line in flight so a jumped counter cannot keep reading
      if (frame_sync_s) begin
         state_s = S_IDLE;
         issue_s = 1'b0;
         load_s  = 1'b0;
         flush_s = 1'b1;
      end else begin
         flush_s = flush_s;
      end
   end

   // State register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_r <= S_IDLE;
      else         state_r <= state_s;
   end

   // Read address: increments per issued word, wraps at frame end, restarts on frame sync
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)              addr_r <= {ADDR_WIDTH{1'b0}};
      else if (frame_sync_s)    addr_r <= {ADDR_WIDTH{1'b0}};
      else if (!issue_s)        addr_r <= addr_r;
      else if (addr_r == ADDR_LAST) addr_r <= {ADDR_WIDTH{1'b0}};
      else                      addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   end

   // Next-word capture one cycle after each issue
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         issue_d_r <= 1'b0;
         nw_r      <= {WORD_W{1'b0}};
         nw_vld_r  <= 1'b0;
      end else begin
         issue_d_r <= issue_s;
         if (frame_sync_s) begin
            nw_vld_r <= 1'b0;
         end else if (issue_d_r) begin
            nw_r     <= mem_data_i;
            nw_vld_r <= 1'b1;
         end else if (load_s) begin
            nw_vld_r <= 1'b0;
         end else begin
            nw_vld_r <= nw_vld_r;
         end
      end
   end

   // Pixel shift register and sticky underrun flag
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sr_r       <= {WORD_W{1'b0}};
         underrun_r <= 1'b0;
      end else begin
         if (flush_s)                sr_r <= {WORD_W{1'b0}};
         else if (load_s)            sr_r <= nw_vld_r ? nw_r : {WORD_W{1'b0}};
         else if (state_r == S_ACTIVE) sr_r <= sr_r >> PXL_WIDTH;
         else                        sr_r <= sr_r;
         if (load_s && !nw_vld_r)    underrun_r <= 1'b1;
         else                        underrun_r <= underrun_r;
      end
   end

   // Pixel output is forced dark outside the active window
   always_comb begin
      if (state_r == S_ACTIVE) mem_pxl_o = sr_r[PXL_WIDTH-1:0];
      else                     mem_pxl_o = {PXL_WIDTH{1'b0}};
   end

   assign mem_en_o   = issue_s;
   assign mem_addr_o = addr_r;
   assign underrun_o = underrun_r;

endmodule

// File: tb/tb_vga_mem_intf.sv
// Directed bench for vga_mem_intf: full-size instance driven with 800x525 counts
// plus a tiny instance used to exercise whole frames and address wrap.
module tb_vga_mem_intf;

   logic        clk = 1'b0;
   logic        rstn;
   int          pxl = 0, ln = 0, spx = 0, sln = 0;
   int          total = 0, bad = 0;
   int          s_reads = 0, s_last = -1;

   logic [9:0]  pxl_ctr, line_ctr;
   logic        mem_en, underrun;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_pxl;

   logic [4:0]  s_pxl_ctr;
   logic [2:0]  s_line_ctr, s_addr;
   logic        s_en, s_underrun, s_pxl;
   logic [7:0]  s_data;

   always #5 clk = ~clk;

   assign pxl_ctr    = pxl[9:0];
   assign line_ctr   = ln[9:0];
   assign s_pxl_ctr  = spx[4:0];
   assign s_line_ctr = sln[2:0];

   vga_mem_intf u_dut (
      .clk_i(clk), .rstn_i(rstn), .pxl_ctr_i(pxl_ctr), .line_ctr_i(line_ctr),
      .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
      .mem_pxl_o(mem_pxl), .underrun_o(underrun)
   );

   vga_mem_intf #(
      .PXL_WIDTH(1), .PXL_PER_ROW(8), .WIDTH_PX(16), .HEIGHT_PX(4),
      .H_B_PORCH_MAX_PX(8), .V_B_PORCH_MAX_LNS(2), .PREFETCH_PX(4),
      .PXL_CTR_WIDTH(5), .LN_CTR_WIDTH(3), .MEM_DEPTH(8), .ADDR_WIDTH(3)
   ) u_small (
      .clk_i(clk), .rstn_i(rstn), .pxl_ctr_i(s_pxl_ctr), .line_ctr_i(s_line_ctr),
      .mem_en_o(s_en), .mem_addr_o(s_addr), .mem_data_i(s_data),
      .mem_pxl_o(s_pxl), .underrun_o(s_underrun)
   );

   function automatic logic [7:0] bram_word(input int a);
      int t;
      t = a * 29;
      return 8'hA6 ^ t[7:0];
   endfunction

   // Single-cycle-latency BRAM models
   always_ff @(posedge clk) begin
      if (mem_en) mem_data <= bram_word(int'(mem_addr));
      if (s_en)   s_data   <= bram_word(int'(s_addr));
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h (line %0d pxl %0d)", tag, obs, exp, ln, pxl);
      end
   endtask

   task automatic step_counters();
      spx = spx + 1;
      if (spx == 32) begin spx = 0; sln = (sln + 1) % 8; end
   endtask

   task automatic adv();
      @(posedge clk); #1;
      pxl = pxl + 1;
      if (pxl == 800) begin pxl = 0; ln = (ln + 1) % 525; end
      step_counters();
      @(negedge clk);
   endtask

   task automatic jump(input int l, input int p);
      @(posedge clk); #1;
      ln = l; pxl = p;
      step_counters();
      @(negedge clk);
   endtask

   task automatic run_idle(input int l, input int p);
      int n;
      n = 0;
      while (!(ln == l && pxl == p)) begin
         chk("idle_en", 32'(mem_en), 32'd0);
         chk("idle_pxl", 32'(mem_pxl), 32'd0);
         adv();
         n++;
         if (n > 30000) begin
            chk("idle_timeout", 32'd1, 32'd0);
            break;
         end
      end
   endtask

   task automatic small_chk();
      logic vis, e, ep;
      logic [7:0] w;
      int off;
      vis = (sln >= 2) && (sln <= 5);
      e   = vis && (spx == 4 || spx == 8);
      chk("small_en", 32'(s_en), 32'(e));
      if (e) chk("small_addr", 32'(s_addr), 32'((sln - 2) * 2 + ((spx == 8) ? 1 : 0)));
      if (s_en) begin s_reads++; s_last = int'(s_addr); end
      if (vis && spx >= 8 && spx <= 23) begin
         off = spx - 8;
         w   = bram_word((sln - 2) * 2 + off / 8);
         ep  = w[off % 8];
      end else begin
         ep = 1'b0;
      end
      chk("small_pxl", 32'(s_pxl), 32'(ep));
   endtask

   task automatic check_line(input int base, input int last_p, output logic [7:0] cap, output int pulses);
      logic e_en, e_px, done;
      logic [7:0] w;
      int off;
      cap = 8'd0; pulses = 0; done = 1'b0;
      while (!done) begin
         e_en = (pxl == 140) || (pxl >= 144 && pxl <= 768 && ((pxl - 144) % 8) == 0);
         chk("line_en", 32'(mem_en), 32'(e_en));
         if (e_en) chk("line_addr", 32'(mem_addr), 32'(base + ((pxl == 140) ? 0 : (pxl - 136) / 8)));
         if (mem_en) pulses++;
         if (pxl >= 144 && pxl <= 783) begin
            off  = pxl - 144;
            w    = bram_word(base + off / 8);
            e_px = w[off % 8];
         end else begin
            e_px = 1'b0;
         end
         chk("line_pxl", 32'(mem_pxl), 32'(e_px));
         if (pxl >= 144 && pxl <= 151) cap[pxl - 144] = mem_pxl;
         done = (pxl == last_p);
         adv();
      end
   endtask

   initial begin
      logic [7:0] cap;
      logic [7:0] w2;
      int pulses;

      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_en", 32'(mem_en), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_pxl", 32'(mem_pxl), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_small_addr", 32'(s_addr), 32'd0);
      rstn = 1'b1;

      // Line 0 on the big instance while the small one runs three whole frames
      for (int i = 0; i < 800; i++) begin
         chk("l0_en", 32'(mem_en), 32'd0);
         chk("l0_pxl", 32'(mem_pxl), 32'd0);
         small_chk();
         adv();
      end
      chk("small_reads", 32'(s_reads), 32'd24);
      chk("small_last_addr", 32'(s_last), 32'd7);
      chk("small_underrun", 32'(s_underrun), 32'd0);

      jump(34, 0);
      run_idle(35, 140);
      chk("pf_addr_l35", 32'(mem_addr), 32'd0);
      check_line(0, 799, cap, pulses);
      chk("word0_pixels", 32'(cap), 32'(8'b1010_0110));
      chk("l35_pulses", 32'(pulses), 32'd80);
      chk("l35_end_addr", 32'(mem_addr), 32'd80);
      chk("l35_underrun", 32'(underrun), 32'd0);

      // Forced frame sync in the middle of line 36
      run_idle(36, 140);
      check_line(80, 200, cap, pulses);
      jump(0, 0);
      adv();
      run_idle(1, 0);
      jump(34, 0);
      run_idle(35, 140);
      chk("sync_addr", 32'(mem_addr), 32'd0);
      chk("sync_underrun", 32'(underrun), 32'd0);
      check_line(0, 150, cap, pulses);

      // Skip the word-2 issue point so the load at off=15 finds nothing buffered
      jump(35, 159);
      chk("skip_en", 32'(mem_en), 32'd0);
      adv();
      chk("underrun_set", 32'(underrun), 32'd1);
      chk("skip_issue_en", 32'(mem_en), 32'd1);
      chk("skip_issue_addr", 32'(mem_addr), 32'd2);
      w2 = bram_word(2);
      for (int i = 0; i < 16; i++) begin
         chk("underrun_pxl", 32'(mem_pxl), 32'((pxl < 168) ? 1'b0 : w2[pxl - 168]));
         adv();
      end
      chk("underrun_sticky", 32'(underrun), 32'd1);

      // Asynchronous reset mid-line
      rstn = 1'b0;
      #1;
      chk("mid_rst_en", 32'(mem_en), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr), 32'd0);
      chk("mid_rst_pxl", 32'(mem_pxl), 32'd0);
      chk("mid_rst_underrun", 32'(underrun), 32'd0);
      adv();
      adv();
      rstn = 1'b1;
      run_idle(36, 140);
      chk("post_rst_addr", 32'(mem_addr), 32'd0);
      check_line(0, 799, cap, pulses);
      chk("post_rst_pulses", 32'(pulses), 32'd80);
      chk("post_rst_underrun", 32'(underrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
